// File: rtl/seven_seg_scan_driver_if.sv
// Display-engine bus: shadow-load inputs and both display styles' outputs.
// The master drives load/digits/blank; the slave (the driver) returns the
// multiplexed and static segment outputs.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 6
);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [7*NUM_DIGITS-1:0] hex_all;
  logic [SLOT_W-1:0]       slot_idx;

  modport master (
    output load, digits, blank,
    input  seg_n, dig_sel, hex_all, slot_idx
  );

  modport slave (
    input  load, digits, blank,
    output seg_n, dig_sel, hex_all, slot_idx
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// N-digit hex to 7-segment engine with time-multiplexed (with anti-ghost
// dead time) and static outputs. Segments are active-low {g,f,e,d,c,b,a}.
// Optional build macro: LEADING_ZERO_BLANK_EN -- darkens leading zero digits
// (digit 0 always stays lit by that rule).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  seven_seg_scan_driver_if.slave bus
);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  // Hex nibble to active-low segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow_digits_reg;
  logic [NUM_DIGITS-1:0]   shadow_blank_reg;
  logic [DIV_W-1:0]        div_cnt_reg;
  logic [SLOT_W-1:0]       slot_idx_reg;
  logic [6:0]              seg_n_reg;
  logic [NUM_DIGITS-1:0]   dig_sel_reg;
  logic [7*NUM_DIGITS-1:0] hex_all_reg;

  logic [NUM_DIGITS-1:0]   blank_eff;
  logic [6:0]              dec_seg [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] hex_all_next;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic                    in_dead;

  // Effective per-digit blanking from the shadow registers.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    blank_eff = shadow_blank_reg;
    zero_run  = 1'b1;
    // Walk from the most significant digit down; stop short of digit 0.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (shadow_digits_reg[4*i +: 4] == 4'd0);
      if (zero_run) blank_eff[i] = 1'b1;
    end
`else
    blank_eff = shadow_blank_reg;
`endif
  end

  // Per-digit decode shared by the static and multiplexed paths.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    assign dec_seg[gi] = blank_eff[gi] ? 7'h7F
                                       : hex_to_seg(shadow_digits_reg[4*gi +: 4]);
    assign hex_all_next[7*gi +: 7] = dec_seg[gi];
  end

  assign in_dead = (int'(div_cnt_reg) < DEAD_CYCLES);

  // Select the currently scanned digit's pattern and its one-hot enable.
  always_comb begin
    seg_next = 7'h7F;
    sel_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_idx_reg == SLOT_W'(i)) begin
        seg_next    = dec_seg[i];
        sel_next[i] = 1'b1;
      end
    end
  end

  // Shadow registers: capture digits/blank on load, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_digits_reg <= '0;
      shadow_blank_reg  <= '1;
    end else if (bus.load) begin
      shadow_digits_reg <= bus.digits;
      shadow_blank_reg  <= bus.blank;
    end
  end

  // Scan divider and slot counter; slot advances when the divider wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg  <= '0;
      slot_idx_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg  <= '0;
      slot_idx_reg <= (slot_idx_reg == SLOT_LAST) ? '0 : slot_idx_reg + SLOT_W'(1);
    end else begin
      div_cnt_reg  <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Registered outputs, one cycle behind the counter state; the dead window
  // at each slot start keeps all enables off so segments can settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n_reg   <= 7'h7F;
      dig_sel_reg <= '0;
      hex_all_reg <= '1;
    end else begin
      hex_all_reg <= hex_all_next;
      if (in_dead) begin
        seg_n_reg   <= 7'h7F;
        dig_sel_reg <= '0;
      end else begin
        seg_n_reg   <= seg_next;
        dig_sel_reg <= sel_next;
      end
    end
  end

  assign bus.seg_n    = seg_n_reg;
  assign bus.dig_sel  = dig_sel_reg;
  assign bus.hex_all  = hex_all_reg;
  assign bus.slot_idx = slot_idx_reg;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (4 digits, 10-cycle slots,
// 2 dead cycles). Stimulus pushes expected output snapshots keyed by clock
// edge number; the monitor pops and compares them after each edge.
module tb_seven_seg_scan_driver;
  localparam int ND = 4;
  localparam int SD = 10;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          at;
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic [1:0]  slot;
    logic [27:0] hex;
    logic [63:0] tag;
  } exp_t;

  exp_t sb[$];
  int pcyc  = 0;
  int total = 0;
  int bad   = 0;
  int e0    = 0;

  // Hand table of the display font.
  function automatic logic [6:0] tab(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [3:0] eff_blank(input logic [15:0] d, input logic [3:0] b);
    logic [3:0] eb;
    eb = b;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zr;
      zr = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        zr = zr & (d[4*i +: 4] == 4'd0);
        if (zr) eb[i] = 1'b1;
      end
    end
`endif
    return eb;
  endfunction

  function automatic logic [27:0] hex_exp(input logic [15:0] d, input logic [3:0] b);
    logic [27:0] h;
    logic [3:0]  eb;
    eb = eff_blank(d, b);
    for (int i = 0; i < 4; i++) h[7*i +: 7] = eb[i] ? 7'h7F : tab(d[4*i +: 4]);
    return h;
  endfunction

  function automatic logic [3:0] sel_exp(input int k);
    if ((k % SD) < DC) return 4'b0000;
    return 4'b0001 << ((k / SD) % ND);
  endfunction

  function automatic logic [1:0] slot_exp(input int k);
    return 2'(((k + 1) / SD) % ND);
  endfunction

  function automatic logic [6:0] seg_exp(input int k, input logic [15:0] d, input logic [3:0] b);
    int s;
    logic [3:0] eb;
    s  = (k / SD) % ND;
    eb = eff_blank(d, b);
    if ((k % SD) < DC) return 7'h7F;
    return eb[s] ? 7'h7F : tab(d[4*s +: 4]);
  endfunction

  task automatic push_one(input int at, input logic [6:0] seg, input logic [3:0] sel,
                          input logic [1:0] slot, input logic [27:0] hex, input logic [63:0] tag);
    exp_t e;
    e.at = at; e.seg = seg; e.sel = sel; e.slot = slot; e.hex = hex; e.tag = tag;
    sb.push_back(e);
  endtask

  // Expected outputs for edges [from,to] given the shadow contents d/b.
  task automatic push_win(input int from, input int to, input logic [15:0] d,
                          input logic [3:0] b, input logic [63:0] tag);
    for (int at = from; at <= to; at++) begin
      push_one(at, seg_exp(at - e0, d, b), sel_exp(at - e0), slot_exp(at - e0),
               hex_exp(d, b), tag);
    end
  endtask

  task automatic wait_until(input int n);
    while (pcyc < n) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph);
    @(negedge clk);
    while (((pcyc - e0) % SD) != ph) @(negedge clk);
  endtask

  // One-cycle load, then check len edges starting two edges later.
  task automatic apply(input logic [15:0] d, input logic [3:0] b,
                       input logic [63:0] tag, input int len);
    int p;
    @(negedge clk);
    bus.load = 1'b1; bus.digits = d; bus.blank = b;
    p = pcyc;
    push_win(p + 2, p + 1 + len, d, b, tag);
    @(negedge clk);
    bus.load = 1'b0;
    wait_until(p + 1 + len);
  endtask

  task automatic cmp(input logic [63:0] tag, input string what,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %0s.%0s cyc=%0d got=%h want=%h", tag, what, pcyc, act, req);
    end
  endtask

  // Monitor: sample 2 time units after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    pcyc = pcyc + 1;
    total++;
    if (!$onehot0(bus.dig_sel)) begin
      bad++;
      $display("FAIL onehot cyc=%0d got=%b want=at most one bit", pcyc, bus.dig_sel);
    end
    while (sb.size() > 0 && sb[0].at <= pcyc) begin
      e = sb.pop_front();
      if (e.at < pcyc) begin
        total++; bad++;
        $display("FAIL %0s.missed got=cyc %0d want=cyc %0d", e.tag, pcyc, e.at);
      end else begin
        cmp(e.tag, "seg_n", 32'(bus.seg_n), 32'(e.seg));
        cmp(e.tag, "dig_sel", 32'(bus.dig_sel), 32'(e.sel));
        cmp(e.tag, "slot_idx", 32'(bus.slot_idx), 32'(e.slot));
        cmp(e.tag, "hex_all", 32'(bus.hex_all), 32'(e.hex));
        $display("chk %0s cyc=%0d seg_n=%h dig_sel=%b slot=%0d hex_all=%h", e.tag, pcyc,
                 bus.seg_n, bus.dig_sel, bus.slot_idx, bus.hex_all);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    bus.load = 1'b0; bus.digits = '0; bus.blank = '0;
    repeat (3) @(negedge clk);

    // Release reset with a load of 4321; first edge shows counter (0,0).
    reset = 1'b0; bus.load = 1'b1; bus.digits = 16'h4321; bus.blank = 4'h0;
    e0 = pcyc + 1;
    push_one(e0, 7'h7F, 4'b0000, 2'd0, 28'hFFFFFFF, "rst_rel");
    push_win(e0 + 1, e0 + 44, 16'h4321, 4'h0, "scan");
    @(negedge clk);
    bus.load = 1'b0;
    wait_until(e0 + 44);

    // Decode sweep over all sixteen nibbles.
    apply(16'h3210, 4'h0, "dec0", 12);
    apply(16'h7654, 4'h0, "dec1", 12);
    apply(16'hBA98, 4'h0, "dec2", 12);
    apply(16'hFEDC, 4'h0, "dec3", 12);

    // Blank inputs darken slots 0 and 2 while enables still pulse.
    apply(16'h8888, 4'b0101, "blank", 40);

    // Mid-slot load 0000 -> FFFF, then changing inputs with load low.
    apply(16'h0000, 4'h0, "zero", 10);
    wait_phase(5);
    bus.load = 1'b1; bus.digits = 16'hFFFF; bus.blank = 4'h0;
    p = pcyc;
    push_one(p + 1, seg_exp(p + 1 - e0, 16'h0000, 4'h0), sel_exp(p + 1 - e0),
             slot_exp(p + 1 - e0), hex_exp(16'h0000, 4'h0), "ld_old");
    push_win(p + 2, p + 25, 16'hFFFF, 4'h0, "ld_hold");
    @(negedge clk);
    bus.load = 1'b0; bus.digits = 16'h1234; bus.blank = 4'hF;
    wait_until(p + 25);

    // Leading-zero cases (expectations follow the build macro).
    apply(16'h0040, 4'h0, "lz0040", 40);
    apply(16'h0000, 4'h0, "lz0000", 40);

    // Reset for 3 cycles mid-slot; outputs idle during and 1 edge after.
    wait_phase(5);
    reset = 1'b1;
    p = pcyc;
    for (int i = 1; i <= 4; i++) push_one(p + i, 7'h7F, 4'b0000, 2'd0, 28'hFFFFFFF, "rst_mid");
    wait_until(p + 3);
    reset = 1'b0;
    e0 = p + 4;
    wait_until(p + 4);

    // Scan restarts from slot 0 after the mid-slot reset.
    apply(16'h4321, 4'h0, "scan2", 25);

    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
